// File: rtl/branch_predict_ctrl.sv
// Branch predictor (2-bit counters + tagged BTB) with mispredict recovery sequencing.
// Tables update on resolve; recovery runs a one-cycle flush, then a redirect held until fetch acks.
module branch_predict_ctrl #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             ex_stall,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ack,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t                  state_q, state_d;
  logic                    flush_q, flush_d;
  logic                    redirect_valid_q, redirect_valid_d;
  logic                    ex_stall_q, ex_stall_d;
  logic [31:0]             redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]        branch_count_q, branch_count_d;
  logic [CNT_W-1:0]        mispredict_count_q, mispredict_count_d;

  logic [DEPTH-1:0][1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]        btb_valid_q, btb_valid_d;
  logic [TAG_W-1:0]        btb_tag_q [DEPTH];
  logic [TAG_W-1:0]        btb_tag_d [DEPTH];
  logic [31:0]             btb_target_q [DEPTH];
  logic [31:0]             btb_target_d [DEPTH];

  logic [IDX_W-1:0]        if_idx, ex_idx;
  logic [TAG_W-1:0]        if_tag, ex_tag;
  logic                    resolve, mispredict;
  logic                    unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];
  assign unused_pc_bits = ^if_pc[1:0];

  always_comb begin
    pred_taken  = cnt_q[if_idx][1] & btb_valid_q[if_idx] & (btb_tag_q[if_idx] == if_tag);
    pred_target = pred_taken ? btb_target_q[if_idx] : 32'd0;
  end

  // Resolves are only accepted in IDLE, which is exactly when the stall is low.
  assign resolve    = ex_valid & ex_is_branch & (state_q == IDLE);
  assign mispredict = (ex_taken != ex_pred_taken) |
                      (ex_taken & ex_pred_taken & (ex_target != ex_pred_target));

  always_comb begin
    cnt_d              = cnt_q;
    btb_valid_d        = btb_valid_q;
    btb_tag_d          = btb_tag_q;
    btb_target_d       = btb_target_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (resolve) begin
      if (ex_taken) begin
        if (cnt_q[ex_idx] != 2'b11) cnt_d[ex_idx] = cnt_q[ex_idx] + 2'b01;
        btb_valid_d[ex_idx]  = 1'b1;
        btb_tag_d[ex_idx]    = ex_tag;
        btb_target_d[ex_idx] = ex_target;
      end else if (cnt_q[ex_idx] != 2'b00) begin
        cnt_d[ex_idx] = cnt_q[ex_idx] - 2'b01;
      end
      if (branch_count_q != '1) branch_count_d = branch_count_q + 1'b1;
      if (mispredict && (mispredict_count_q != '1))
        mispredict_count_d = mispredict_count_q + 1'b1;
    end
  end

  always_comb begin
    state_d          = state_q;
    flush_d          = 1'b0;
    redirect_valid_d = redirect_valid_q;
    ex_stall_d       = ex_stall_q;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (resolve && mispredict) begin
          state_d          = FLUSH;
          flush_d          = 1'b1;
          redirect_valid_d = 1'b1;
          ex_stall_d       = 1'b1;
          redirect_pc_d    = ex_taken ? ex_target : ex_pc + 32'd4;
        end
      end
      FLUSH: begin
        state_d          = REDIRECT;
        redirect_valid_d = 1'b1;
        ex_stall_d       = 1'b1;
      end
      REDIRECT: begin
        if (redirect_ack) begin
          state_d          = IDLE;
          redirect_valid_d = 1'b0;
          ex_stall_d       = 1'b0;
        end
      end
      default: begin
        state_d          = IDLE;
        redirect_valid_d = 1'b0;
        ex_stall_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      flush_q            <= 1'b0;
      redirect_valid_q   <= 1'b0;
      ex_stall_q         <= 1'b0;
      redirect_pc_q      <= 32'd0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      cnt_q              <= {DEPTH{2'b01}};
      btb_valid_q        <= '0;
      btb_tag_q          <= '{default: '0};
      btb_target_q       <= '{default: '0};
    end else begin
      state_q            <= state_d;
      flush_q            <= flush_d;
      redirect_valid_q   <= redirect_valid_d;
      ex_stall_q         <= ex_stall_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      cnt_q              <= cnt_d;
      btb_valid_q        <= btb_valid_d;
      btb_tag_q          <= btb_tag_d;
      btb_target_q       <= btb_target_d;
    end
  end

  assign flush            = flush_q;
  assign redirect_valid   = redirect_valid_q;
  assign ex_stall         = ex_stall_q;
  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: prediction, table training, recovery handshake and reset.
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_stall, flush, redirect_valid, redirect_ack;
  logic [31:0] redirect_pc;
  logic [15:0] branch_count, mispredict_count;

  int vectors = 0;
  int miscompares = 0;

  branch_predict_ctrl #(.IDX_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_target(ex_target), .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_stall(ex_stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] target,
                               input logic taken, input logic ptaken, input logic [31:0] ptarget);
    ex_valid       = valid;
    ex_is_branch   = valid;
    ex_pc          = pc;
    ex_target      = target;
    ex_taken       = taken;
    ex_pred_taken  = ptaken;
    ex_pred_target = ptarget;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_flush"}, {31'd0, flush}, 32'd0);
    checkOutput({tag, "_rv"}, {31'd0, redirect_valid}, 32'd0);
    checkOutput({tag, "_stall"}, {31'd0, ex_stall}, 32'd0);
  endtask

  task automatic checkPred(input string tag, input logic [31:0] pc, input logic exp_taken, input logic [31:0] exp_target);
    if_pc = pc;
    #1;
    checkOutput({tag, "_ptaken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
    checkOutput({tag, "_ptarget"}, pred_target, exp_target);
  endtask

  // Flush cycle already observed; walk FLUSH->REDIRECT->ack->IDLE.
  task automatic recover(input string tag, input logic [31:0] exp_pc);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    step();
    checkOutput({tag, "_flush_one_cycle"}, {31'd0, flush}, 32'd0);
    checkOutput({tag, "_rv_redirect"}, {31'd0, redirect_valid}, 32'd1);
    checkOutput({tag, "_stall_redirect"}, {31'd0, ex_stall}, 32'd1);
    checkOutput({tag, "_rpc_redirect"}, redirect_pc, exp_pc);
    redirect_ack = 1'b1;
    step();
    redirect_ack = 1'b0;
    checkIdle({tag, "_after_ack"});
  endtask

  initial begin
    rst = 1'b1;
    if_pc = 32'h100;
    redirect_ack = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    step();
    step();
    rst = 1'b0;

    checkPred("reset", 32'h100, 1'b0, 32'd0);
    checkOutput("reset_bcnt", {16'd0, branch_count}, 32'd0);
    checkOutput("reset_mcnt", {16'd0, mispredict_count}, 32'd0);
    checkOutput("reset_rpc", redirect_pc, 32'd0);
    checkIdle("reset");

    // First taken resolve, predicted not-taken: mispredict to 0x80, counter 01->10.
    applyStimulus(1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'd0);
    step();
    checkOutput("mp1_flush", {31'd0, flush}, 32'd1);
    checkOutput("mp1_rv", {31'd0, redirect_valid}, 32'd1);
    checkOutput("mp1_stall", {31'd0, ex_stall}, 32'd1);
    checkOutput("mp1_rpc", redirect_pc, 32'h80);
    checkOutput("mp1_bcnt", {16'd0, branch_count}, 32'd1);
    checkOutput("mp1_mcnt", {16'd0, mispredict_count}, 32'd1);
    checkPred("mp1_pred", 32'h100, 1'b1, 32'h80);
    recover("mp1", 32'h80);

    // Three not-taken resolves: 10->01 (mispredict), 01->00, 00 stays 00.
    applyStimulus(1'b1, 32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
    step();
    checkOutput("nt1_flush", {31'd0, flush}, 32'd1);
    checkOutput("nt1_rpc", redirect_pc, 32'h104);
    recover("nt1", 32'h104);
    applyStimulus(1'b1, 32'h100, 32'h80, 1'b0, 1'b0, 32'd0);
    step();
    checkIdle("nt2");
    applyStimulus(1'b1, 32'h100, 32'h80, 1'b0, 1'b0, 32'd0);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkIdle("nt3");
    checkPred("nt3_sat", 32'h100, 1'b0, 32'd0);
    checkOutput("nt3_bcnt", {16'd0, branch_count}, 32'd4);
    checkOutput("nt3_mcnt", {16'd0, mispredict_count}, 32'd2);

    // Train back to 10 (one mispredict, one correct), then probe an alias.
    applyStimulus(1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'd0);
    step();
    checkOutput("tr1_flush", {31'd0, flush}, 32'd1);
    recover("tr1", 32'h80);
    checkPred("tr1_pred", 32'h100, 1'b0, 32'd0);
    applyStimulus(1'b1, 32'h100, 32'h80, 1'b1, 1'b1, 32'h80);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    checkIdle("tr2_correct");
    checkPred("alias_own", 32'h100, 1'b1, 32'h80);
    checkPred("alias_other", 32'h140, 1'b0, 32'd0);
    checkOutput("tr2_bcnt", {16'd0, branch_count}, 32'd6);
    checkOutput("tr2_mcnt", {16'd0, mispredict_count}, 32'd3);

    // Target mismatch with late ack; resolves offered during the stall must be ignored.
    applyStimulus(1'b1, 32'h100, 32'h80, 1'b1, 1'b1, 32'h90);
    step();
    checkOutput("tgt_flush", {31'd0, flush}, 32'd1);
    checkOutput("tgt_rpc", redirect_pc, 32'h80);
    checkOutput("tgt_mcnt", {16'd0, mispredict_count}, 32'd4);
    applyStimulus(1'b1, 32'h204, 32'h300, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("hold_rv", {31'd0, redirect_valid}, 32'd1);
      checkOutput("hold_rpc", redirect_pc, 32'h80);
      checkOutput("hold_stall", {31'd0, ex_stall}, 32'd1);
    end
    checkOutput("hold_bcnt", {16'd0, branch_count}, 32'd7);
    checkOutput("hold_mcnt", {16'd0, mispredict_count}, 32'd4);
    checkPred("hold_nobtb", 32'h204, 1'b0, 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    redirect_ack = 1'b1;
    step();
    redirect_ack = 1'b0;
    checkIdle("tgt_after_ack");

    // Fall-through redirect wraps past the top of the address space.
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h40, 1'b0, 1'b1, 32'h40);
    step();
    checkOutput("wrap_rpc", redirect_pc, 32'd0);
    recover("wrap", 32'd0);

    // Reset while in REDIRECT abandons recovery and clears the tables.
    applyStimulus(1'b1, 32'h100, 32'h80, 1'b0, 1'b1, 32'h80);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    step();
    checkOutput("prerst_rv", {31'd0, redirect_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkIdle("midrst");
    checkOutput("midrst_rpc", redirect_pc, 32'd0);
    checkOutput("midrst_bcnt", {16'd0, branch_count}, 32'd0);
    checkOutput("midrst_mcnt", {16'd0, mispredict_count}, 32'd0);
    checkPred("midrst_pred", 32'h100, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
